// File: rtl/div_unit_pkg.sv
// Shared widths and FSM encodings for the iterative divide unit.
package div_unit_pkg;
  localparam int W_DATA = 32;
  localparam int W_TAG  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_CALC   = 2'd1,
    DIV_FIX    = 2'd2,
    DIV_RESULT = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int W_DATA = div_unit_pkg::W_DATA
) (
  input  logic [W_DATA-1:0] rem,
  input  logic [W_DATA-1:0] quo,
  input  logic [W_DATA-1:0] dvsr,
  output logic [W_DATA-1:0] rem_next,
  output logic [W_DATA-1:0] quo_next
);
  import div_unit_pkg::*;

  logic [W_DATA-1:0] rem_sh;
  logic [W_DATA:0]   diff;
  logic              rem_top_unused;

  // The shifted-out remainder MSB is always zero for a nonzero divisor; for a zero
  // divisor dropping it is what makes the loop return all ones.
  assign rem_top_unused = rem[W_DATA-1];
  assign rem_sh         = {rem[W_DATA-2:0], quo[W_DATA-1]};
  assign diff           = {1'b0, rem_sh} - {1'b0, dvsr};

  always_comb begin
    quo_next = {quo[W_DATA-2:0], ~diff[W_DATA]};
    rem_next = diff[W_DATA] ? rem_sh : diff[W_DATA-1:0];
  end
endmodule

// File: rtl/div_unit.sv
// Unpipelined signed 32-bit divider between the divide issue queue and CDB arbitration.
module div_unit #(
  parameter int W_DATA = div_unit_pkg::W_DATA,
  parameter int W_TAG  = div_unit_pkg::W_TAG,
  parameter int W_CNT  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              equeuediv_ready,
  input  logic [W_TAG-1:0]  equeuediv_rdtag,
  input  logic [W_DATA-1:0] equeuediv_rsdata,
  input  logic [W_DATA-1:0] equeuediv_rtdata,
  output logic              equeuediv_done,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [W_TAG-1:0]  cdb_req_tag,
  output logic [W_DATA-1:0] cdb_req_data,
  output logic              busy
);
  import div_unit_pkg::*;

  div_state_e        state, state_next;
  logic [W_CNT-1:0]  cnt;
  logic [W_DATA-1:0] rem, quo, dvsr;
  logic [W_DATA-1:0] rem_next, quo_next;
  logic [W_DATA-1:0] res_data;
  logic [W_TAG-1:0]  res_tag;
  logic              neg;
  logic              last_iter;

  // Unsigned magnitude; the most negative value maps onto itself as 2^(W_DATA-1).
  function automatic logic [W_DATA-1:0] mag(input logic [W_DATA-1:0] x);
    return x[W_DATA-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [W_DATA-1:0] sign_fix(input logic [W_DATA-1:0] q, input logic n);
    return n ? (~q + 1'b1) : q;
  endfunction

  assign last_iter = (cnt == W_CNT'(W_DATA - 1));

  div_step #(.W_DATA(W_DATA)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvsr     (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE:   if (equeuediv_ready) state_next = DIV_CALC;
      DIV_CALC:   if (last_iter)       state_next = DIV_FIX;
      DIV_FIX:                         state_next = DIV_RESULT;
      DIV_RESULT: if (cdb_grant)       state_next = DIV_IDLE;
      default:                         state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    equeuediv_done = (state == DIV_IDLE) & equeuediv_ready;
    cdb_req        = (state == DIV_RESULT);
    busy           = (state != DIV_IDLE);
  end

  // Accept / iterate / sign-fix; tag and result are held untouched through RESULT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg      <= 1'b0;
      res_tag  <= '0;
      res_data <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (equeuediv_ready) begin
            res_tag <= equeuediv_rdtag;
            quo     <= mag(equeuediv_rsdata);
            dvsr    <= mag(equeuediv_rtdata);
            neg     <= equeuediv_rsdata[W_DATA-1] ^ equeuediv_rtdata[W_DATA-1];
            rem     <= '0;
            cnt     <= '0;
          end
        end
        DIV_CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
        end
        DIV_FIX: res_data <= sign_fix(quo, neg);
        default: ;
      endcase
    end
  end

  assign cdb_req_tag  = res_tag;
  assign cdb_req_data = res_data;
endmodule

// File: tb/tb_div_unit.sv
// Directed and table-driven checks of div_unit: latency, signs, zero divisor, back-pressure, reset.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [5:0]  rdtag;
  logic [31:0] rsdata, rtdata;
  logic        done;
  logic        req;
  logic        grant;
  logic [5:0]  req_tag;
  logic [31:0] req_data;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  div_unit dut (
    .clk              (clk),
    .reset            (reset),
    .equeuediv_ready  (ready),
    .equeuediv_rdtag  (rdtag),
    .equeuediv_rsdata (rsdata),
    .equeuediv_rtdata (rtdata),
    .equeuediv_done   (done),
    .cdb_req          (req),
    .cdb_grant        (grant),
    .cdb_req_tag      (req_tag),
    .cdb_req_data     (req_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge one cycle after the accept edge.
  task automatic issue(input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] tag,
                       input string nm);
    int k;
    ready = 1'b1; rsdata = rs; rtdata = rt; rdtag = tag;
    #1;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk); #1; k++;
    end
    chk({nm, " accept"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    chk({nm, " done 1-cycle"}, {31'd0, done}, 32'd0);
    ready = 1'b0;
  endtask

  task automatic finish(input logic [5:0] tag, input logic [31:0] exp, input int gdelay,
                        input logic exp_done_after, input string nm);
    int lat;
    lat   = 1;
    grant = 1'b0;
    while (!req && lat < 80) begin
      @(negedge clk); lat++;
    end
    chk({nm, " latency"}, lat, 34);
    chk({nm, " tag"}, {26'd0, req_tag}, {26'd0, tag});
    chk({nm, " data"}, req_data, exp);
    for (int i = 0; i < gdelay; i++) begin
      @(negedge clk);
      chk({nm, " hold req"}, {31'd0, req}, 32'd1);
      chk({nm, " hold tag"}, {26'd0, req_tag}, {26'd0, tag});
      chk({nm, " hold data"}, req_data, exp);
      chk({nm, " hold done"}, {31'd0, done}, 32'd0);
    end
    grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
    chk({nm, " req drop"}, {31'd0, req}, 32'd0);
    chk({nm, " done after grant"}, {31'd0, done}, {31'd0, exp_done_after});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [31:0] sa, sb, sq;
    int k;

    vecs[0] = '{32'd100,        32'd7,          6'd12, 32'd14};
    vecs[1] = '{32'hFFFFFF9C,   32'd7,          6'd13, 32'hFFFFFFF2};
    vecs[2] = '{32'd100,        32'hFFFFFFF9,   6'd14, 32'hFFFFFFF2};
    vecs[3] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   6'd15, 32'd14};
    vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   6'd16, 32'h80000000};
    vecs[5] = '{32'd5,          32'd0,          6'd17, 32'hFFFFFFFF};
    vecs[6] = '{32'hFFFFFFFB,   32'd0,          6'd18, 32'h00000001};
    vecs[7] = '{32'd0,          32'd0,          6'd19, 32'hFFFFFFFF};
    vecs[8] = '{32'd7,          32'd100,        6'd63, 32'd0};
    vecs[9] = '{32'hFFFFFFFF,   32'd1,          6'd1,  32'hFFFFFFFF};

    reset = 1'b1; ready = 1'b0; grant = 1'b0;
    rdtag = '0; rsdata = '0; rtdata = '0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset req", {31'd0, req}, 32'd0);
    chk("reset tag", {26'd0, req_tag}, 32'd0);
    chk("reset data", req_data, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].rs, vecs[i].rt, vecs[i].tag, $sformatf("vec%0d", i));
      finish(vecs[i].tag, vecs[i].exp, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-pressure with a second entry waiting in the queue.
    issue(32'd200, 32'hFFFFFFF8, 6'd30, "bp1");
    ready = 1'b1; rsdata = 32'd77; rtdata = 32'hFFFFFFF9; rdtag = 6'd31;
    finish(6'd30, 32'hFFFFFFE7, 5, 1'b1, "bp1");
    issue(32'd77, 32'hFFFFFFF9, 6'd31, "bp2");
    finish(6'd31, 32'hFFFFFFF5, 0, 1'b0, "bp2");

    // Reset during CALC iteration 10 with another entry pending.
    issue(32'd50, 32'd5, 6'd4, "rst_calc0");
    ready = 1'b1; rsdata = 32'd1000; rtdata = 32'd10; rdtag = 6'd9;
    repeat (9) @(negedge clk);
    chk("rst_calc busy before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_calc busy", {31'd0, busy}, 32'd0);
    chk("rst_calc req", {31'd0, req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(32'd1000, 32'd10, 6'd9, "rst_calc");
    finish(6'd9, 32'd100, 0, 1'b0, "rst_calc");

    // Reset while a result waits for grant.
    issue(32'd7, 32'd2, 6'd3, "rst_res");
    grant = 1'b0;
    k = 1;
    while (!req && k < 80) begin
      @(negedge clk); k++;
    end
    chk("rst_res req up", {31'd0, req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_res req", {31'd0, req}, 32'd0);
    chk("rst_res busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back random signed stream against a truncating reference.
    for (int t = 0; t < 4; t++) begin
      sa = $signed($urandom);
      sb = $signed($urandom_range(1, 5000));
      if ($urandom_range(0, 1) == 1) sb = -sb;
      sq = sa / sb;
      issue(sa, sb, 6'(20 + t), $sformatf("rnd%0d", t));
      finish(6'(20 + t), sq, int'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
